// File: rtl/ero_dil_mode_ctrl.sv
// ero_dil_mode_ctrl: debounced key plus frame-count mode sequencing, applied only at frame start
module ero_dil_mode_ctrl #(
    parameter logic [19:0] DEB_CNT     = 20'd1_000_000,
    parameter logic [7:0]  AUTO_FRAMES = 8'd120,
    parameter logic [7:0]  THRESH      = 8'd128
) (
    input  logic       pix_clk,
    input  logic       rstn,
    input  logic       vs_in,
    input  logic       key_n,
    input  logic       auto_en,
    output logic [2:0] mode,
    output logic       bin_en,
    output logic [1:0] s1_sel,
    output logic [1:0] s2_sel,
    output logic [7:0] thresh,
    output logic       mode_chg
);
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} deb_t;
    deb_t        st;
    logic        k1, k2, press, vs_d, armed, fs, adv;
    logic [19:0] cnt;
    logic [7:0]  fcnt;
    logic [2:0]  pend, pend_eff, pend_nxt, mode_nxt;
    logic [4:0]  dec;
    function automatic logic [2:0] nxt(input logic [2:0] x);
        return (x == 3'd5) ? 3'd0 : x + 3'd1;
    endfunction
    assign thresh = THRESH;
    // armed masks the first cycle after reset so a vs_in already high does not look like a rising edge
    always_comb begin
        fs       = vs_in & ~vs_d & armed;
        adv      = auto_en & (fcnt == AUTO_FRAMES - 8'd1);
        pend_eff = press ? nxt(pend) : pend;
        pend_nxt = nxt(pend_eff);
        mode_nxt = adv ? pend_nxt : pend_eff;
        dec      = (mode_nxt == 3'd1) ? 5'b1_00_00 :
                   (mode_nxt == 3'd2) ? 5'b1_01_00 :
                   (mode_nxt == 3'd3) ? 5'b1_10_00 :
                   (mode_nxt == 3'd4) ? 5'b1_01_10 :
                   (mode_nxt == 3'd5) ? 5'b1_10_01 : 5'b0_00_00;
    end
    // two-flop synchronizer for the asynchronous key, idle level is released (1)
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            k1 <= 1'b1;
            k2 <= 1'b1;
        end else begin
            k1 <= key_n;
            k2 <= k1;
        end
    end
    // debounce FSM: the detecting IDLE cycle counts as the first stable sample, one press per physical press
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            st    <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (st)
                IDLE: if (!k2) begin
                    st  <= PRESS_CHK;
                    cnt <= 20'd1;
                end
                PRESS_CHK: if (k2) begin
                    st  <= IDLE;
                    cnt <= '0;
                end else if (cnt >= DEB_CNT - 20'd1) begin
                    st    <= HELD;
                    press <= 1'b1;
                    cnt   <= '0;
                end else cnt <= cnt + 20'd1;
                HELD: if (k2) begin
                    st  <= REL_CHK;
                    cnt <= 20'd1;
                end
                REL_CHK: if (!k2) begin
                    st  <= HELD;
                    cnt <= '0;
                end else if (cnt >= DEB_CNT - 20'd1) begin
                    st  <= IDLE;
                    cnt <= '0;
                end else cnt <= cnt + 20'd1;
                default: begin
                    st  <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end
    // pending mode accumulates presses; frame start commits it (plus auto advance) to mode and decode
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            vs_d     <= 1'b0;
            armed    <= 1'b0;
            fcnt     <= '0;
            pend     <= '0;
            mode     <= '0;
            bin_en   <= 1'b0;
            s1_sel   <= '0;
            s2_sel   <= '0;
            mode_chg <= 1'b0;
        end else begin
            vs_d     <= vs_in;
            armed    <= 1'b1;
            mode_chg <= 1'b0;
            pend     <= (fs && adv) ? pend_nxt : pend_eff;
            if (fs) begin
                mode                     <= mode_nxt;
                {bin_en, s1_sel, s2_sel} <= dec;
                mode_chg                 <= (mode_nxt != mode);
                fcnt                     <= adv ? 8'd0 : auto_en ? fcnt + 8'd1 : 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_ero_dil_mode_ctrl.sv
// tb_ero_dil_mode_ctrl: directed vector table plus hand sequences for bounce, auto, coincidence and reset
module tb_ero_dil_mode_ctrl;
    logic       pix_clk = 1'b0, rstn = 1'b0, vs_in = 1'b0, key_n = 1'b1, auto_en = 1'b0;
    logic [2:0] mode;
    logic       bin_en, mode_chg;
    logic [1:0] s1_sel, s2_sel;
    logic [7:0] thresh;
    int         n_cmp = 0, n_bad = 0;
    typedef struct {int presses; logic [2:0] m; logic [4:0] d; logic c;} vec_t;
    vec_t tv[9];
    ero_dil_mode_ctrl #(.DEB_CNT(20'd16), .AUTO_FRAMES(8'd3), .THRESH(8'd128)) dut (
        .pix_clk(pix_clk), .rstn(rstn), .vs_in(vs_in), .key_n(key_n), .auto_en(auto_en),
        .mode(mode), .bin_en(bin_en), .s1_sel(s1_sel), .s2_sel(s2_sel),
        .thresh(thresh), .mode_chg(mode_chg)
    );
    always #5 pix_clk = ~pix_clk;
    function automatic logic [4:0] dec(input logic [2:0] m);
        return (m == 3'd1) ? 5'b10000 : (m == 3'd2) ? 5'b10100 : (m == 3'd3) ? 5'b11000 :
               (m == 3'd4) ? 5'b10110 : (m == 3'd5) ? 5'b11001 : 5'b00000;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pix_clk);
            #1;
        end
    endtask
    task automatic press();
        key_n = 1'b0;
        tick(40);
        key_n = 1'b1;
        tick(30);
    endtask
    task automatic frame(input logic [2:0] m, input logic [4:0] d, input logic c);
        vs_in = 1'b1;
        tick();
        chk("mode", mode, m);
        chk("decode", {bin_en, s1_sel, s2_sel}, d);
        chk("mode_chg", mode_chg, c);
        chk("thresh", thresh, 8'd128);
        tick();
        chk("chg_pulse_end", mode_chg, 1'b0);
        vs_in = 1'b0;
        tick(4);
    endtask
    initial begin
        logic [2:0] prev;
        tv[0] = '{1, 3'd1, 5'b10000, 1'b1};
        tv[1] = '{1, 3'd2, 5'b10100, 1'b1};
        tv[2] = '{1, 3'd3, 5'b11000, 1'b1};
        tv[3] = '{1, 3'd4, 5'b10110, 1'b1};
        tv[4] = '{1, 3'd5, 5'b11001, 1'b1};
        tv[5] = '{1, 3'd0, 5'b00000, 1'b1};
        tv[6] = '{0, 3'd0, 5'b00000, 1'b0};
        tv[7] = '{2, 3'd2, 5'b10100, 1'b1};
        tv[8] = '{8, 3'd4, 5'b10110, 1'b1};
        tick(3);
        chk("rst_mode", mode, 3'd0);
        chk("rst_decode", {bin_en, s1_sel, s2_sel}, 5'd0);
        chk("rst_chg", mode_chg, 1'b0);
        chk("rst_thresh", thresh, 8'd128);
        rstn = 1'b1;
        tick(5);
        repeat (3) frame(3'd0, 5'd0, 1'b0);
        prev = 3'd0;
        for (int i = 0; i < 9; i++) begin
            repeat (tv[i].presses) press();
            chk("hold_until_fs", mode, prev);
            frame(tv[i].m, tv[i].d, tv[i].c);
            prev = tv[i].m;
        end
        key_n = 1'b0;
        tick(10);
        key_n = 1'b1;
        tick(5);
        key_n = 1'b0;
        tick(40);
        key_n = 1'b1;
        tick(6);
        key_n = 1'b0;
        tick(5);
        key_n = 1'b1;
        tick(30);
        chk("bounce_hold", mode, 3'd4);
        frame(3'd5, dec(3'd5), 1'b1);
        auto_en = 1'b1;
        frame(3'd5, dec(3'd5), 1'b0);
        frame(3'd5, dec(3'd5), 1'b0);
        frame(3'd0, dec(3'd0), 1'b1);
        frame(3'd0, dec(3'd0), 1'b0);
        frame(3'd0, dec(3'd0), 1'b0);
        key_n = 1'b0;
        tick(18);
        frame(3'd2, dec(3'd2), 1'b1);
        key_n = 1'b1;
        tick(30);
        frame(3'd2, dec(3'd2), 1'b0);
        auto_en = 1'b0;
        frame(3'd2, dec(3'd2), 1'b0);
        press();
        frame(3'd3, dec(3'd3), 1'b1);
        key_n = 1'b0;
        tick(10);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_mode", mode, 3'd0);
        chk("async_rst_decode", {bin_en, s1_sel, s2_sel}, 5'd0);
        chk("async_rst_thresh", thresh, 8'd128);
        tick(2);
        rstn = 1'b1;
        tick(12);
        key_n = 1'b1;
        tick(30);
        frame(3'd0, dec(3'd0), 1'b0);
        press();
        frame(3'd1, dec(3'd1), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ero_dil_mode_ctrl.md
# ero_dil_mode_ctrl

Frame-synchronous mode controller for the HDMI erosion/dilation demo. It sits between the board key and the morphology datapath, alongside `sync_vg` and `video_display`, in the `pix_clk` domain. It debounces a push-button and optionally auto-cycles the processing mode on a frame count. Mode changes are applied only at the start of a frame, so the binarize, erosion and dilation stages never switch mid-picture.

## Interface
Parameters:
- `DEB_CNT`, default 20'd1_000_000: number of stable `pix_clk` cycles needed to accept a key level change (about 6.7 ms at 148.5 MHz).
- `AUTO_FRAMES`, default 8'd120: frames per mode in auto mode. Legal range is 1..255.
- `THRESH`, default 8'd128: binarization threshold, driven out constantly.

Ports (one clock; reset is asynchronous and active-low):
- `pix_clk`, in, 1: pixel clock. All logic is on its rising edge.
- `rstn`, in, 1: asynchronous active-low reset.
- `vs_in`, in, 1: vertical sync from the timing generator, active high.
- `key_n`, in, 1: raw push-button, active low, asynchronous to `pix_clk`.
- `auto_en`, in, 1: when high, enables automatic mode cycling. Treated as static; sampled only at frame start.
- `mode`, out, 3: active mode, 0..5.
- `bin_en`, out, 1: enables the binarize stage.
- `s1_sel`, out, 2: first morphology stage. 00 = bypass, 01 = erode, 10 = dilate.
- `s2_sel`, out, 2: second morphology stage, same encoding as `s1_sel`.
- `thresh`, out, 8: equals `THRESH`.
- `mode_chg`, out, 1: one-cycle pulse when `mode` changes value.

## Operation
- Key path:
  - `key_n` passes through a 2-flop synchronizer.
  - Debounce FSM states: `IDLE` (released), `PRESS_CHK`, `HELD`, `REL_CHK`.
  - `IDLE` goes to `PRESS_CHK` when the synced key is 0.
  - `PRESS_CHK` counts cycles while the key stays 0. On a count of `DEB_CNT` it goes to `HELD` and emits a one-cycle `press`. Any 1 during the count returns to `IDLE` and clears the counter.
  - `HELD` goes to `REL_CHK` when the key is 1. `REL_CHK` returns to `IDLE` after `DEB_CNT` stable 1s; any 0 returns to `HELD`.
  - Exactly one `press` per physical press.
- Pending mode register `pend`:
  - `pend_eff` = `press` ? next(`pend`) : `pend`.
  - next(x) = x+1, wrapping 5 -> 0.
  - `pend` <= `pend_eff` every cycle, unless overridden by auto advance.
- Frame start `fs` is `vs_in & ~vs_d`, where `vs_d` is `vs_in` registered. On `fs`:
  - If `auto_en` and `fcnt == AUTO_FRAMES-1`: `mode` <= next(`pend_eff`), `pend` <= next(`pend_eff`), `fcnt` <= 0.
  - Else: `mode` <= `pend_eff`, and `fcnt` <= `fcnt`+1 if `auto_en`, otherwise 0.
- `fcnt` is 8 bits and holds its value between `fs` events.
- Mode decode, registered and updated in the same cycle as `mode`:
  - Mode 0, original: `bin_en`=0, `s1_sel`=00, `s2_sel`=00.
  - Mode 1, binary: `bin_en`=1, `s1_sel`=00, `s2_sel`=00.
  - Mode 2, erode: `bin_en`=1, `s1_sel`=01, `s2_sel`=00.
  - Mode 3, dilate: `bin_en`=1, `s1_sel`=10, `s2_sel`=00.
  - Mode 4, open: `bin_en`=1, `s1_sel`=01, `s2_sel`=10.
  - Mode 5, close: `bin_en`=1, `s1_sel`=10, `s2_sel`=01.
- `mode_chg` is 1 for the single cycle in which a new `mode` value becomes visible. It stays 0 if `fs` writes the same value.
- Reset (asynchronous, any time, including mid-debounce or mid-frame):
  - `mode`, `pend`, `fcnt`, `bin_en`, `s1_sel`, `s2_sel`, `mode_chg` = 0.
  - `vs_d` = 0 and synchronizer flops = 1.
  - Debounce FSM = `IDLE`, with counter 0.
  - `thresh` = `THRESH`.
- If `vs_in` is high when `rstn` is released, that frame has no `fs`; the first `fs` is the next rising edge.

## Timing
- `fs` latency: `vs_in` rising at edge N gives `fs` high in cycle N. `mode`, the decode outputs and `mode_chg` update at edge N+1.
- Key latency: 2 sync cycles + `DEB_CNT` cycles to `press`. `press` is visible in `pend` one cycle later.
- A press coinciding with `fs` is included via `pend_eff`; it is not lost or deferred.
- Multiple presses within one frame accumulate in `pend` mod 6. Only the value at `fs` is applied.
- Outputs never change except in the cycle after `fs` or on reset.

## Test plan
- Reset, then `rstn` high with `auto_en`=0 and no key: all outputs stay 0, `thresh`=128, across 3 frames.
- Bench `DEB_CNT`=16. A clean 40-cycle `key_n` low mid-frame: `mode` stays 0 until the next `vs_in` rise, then `mode`=1, `bin_en`=1 and `mode_chg` pulses once, one cycle after the rise.
- Key bounce: 10-cycle low, 5-cycle high, then a 40-cycle low produces exactly one advance. A release-bounce of 5 low cycles within `REL_CHK` produces no second press.
- Six presses spread over 6 frames: `mode` goes 1,2,3,4,5,0. Select outputs match the decode list at each step (mode 4: 01/10, mode 5: 10/01).
- `auto_en`=1 with `AUTO_FRAMES`=3: `mode` advances on every 3rd `fs`. A press landing in the same cycle as the advancing `fs` moves `mode` by 2 (0 -> 2).
- Drop `rstn` low mid-`PRESS_CHK` while `mode`=3: outputs go to 0 immediately without a clock. After release, a press needs the full `DEB_CNT` again.
